p2s_ser: RTL and testbench
==========================

Name: p2s_ser

Overview:
Parametrised parallel-to-serial transmitter driving external shift-register chains (LED, segment and switch-sense 74HC595-style) on the SWORD board.
- Successor of the fixed 16-bit shifter. Adds configurable width, bit order and divided free-running-free serial clock; no gated clk.
- Adds a timed latch strobe, a busy/done handshake and synchronous reset.
- Sits between display/LED controllers (parallel words) and board pins.

Parameters:
- DATA_BITS, 16: serial word length, >=2.
- CLK_DIV, 2: sclk half-period in clk cycles, >=1.
- LSB_FIRST, 0: 0 shifts data[DATA_BITS-1] first; 1 shifts data[0] first.
- LATCH_CYCLES, 2: sen pulse length in clk cycles, >=1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  transfer request; rising edge triggers.
- data  in  DATA_BITS  parallel word, sampled on the trigger edge only.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when the latch completes.
- sclk  out  1  registered serial clock to the external chain.
- sout  out  1  registered serial data.
- sclr  out  1  active-low clear to the external chain.
- sen  out  1  latch/output strobe, active-high.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, sclk=0, sout=0, sen=0, busy=0, done=0, start_d=0, counters=0.
  - sclr=0 in every cycle rst is sampled high; sclr=1 otherwise.
  - Reset mid-transfer aborts immediately: no sen pulse, no done pulse.
- Edge detect: register start_d<=start. trig = start & ~start_d & (state==IDLE).
  - start held high triggers only once.
  - Edges while busy are dropped, not queued.
- States: IDLE -> SHIFT -> LATCH -> IDLE. All outputs are registered.
- IDLE:
  - On trig, capture data into shreg, bit_cnt=0, div_cnt=0.
  - Drive sout = first bit (MSB or LSB per LSB_FIRST), sclk=0.
  - busy=1 from the next cycle; go to SHIFT.
- SHIFT: each bit occupies 2*CLK_DIV cycles.
  - sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sout is stable across the whole bit; the external device samples on the sclk rising edge.
  - At the end of each high phase: sclk<=0, shreg shifts, sout<=next bit, bit_cnt++.
  - After the high phase of bit DATA_BITS-1: sclk<=0, sout<=0, go to LATCH.
- LATCH:
  - sen=1 for exactly LATCH_CYCLES cycles; sclk stays 0.
  - On the last cycle, go to IDLE with busy<=0 and done<=1 for one cycle.
- Latency:
  - First sclk rise is CLK_DIV+1 cycles after the trigger edge.
  - busy high for DATA_BITS*2*CLK_DIV + LATCH_CYCLES cycles.
  - done asserts in the first cycle busy is low.
  - Exactly DATA_BITS sclk rising edges per transfer.
- Back-to-back: a start edge in the same cycle done is high is accepted (state is IDLE).
- Counter widths:
  - div_cnt: $clog2(CLK_DIV)+1 bits.
  - bit_cnt: $clog2(DATA_BITS)+1 bits.
  - No wrap-around in legal operation; counters are cleared on trig.
- data changes after capture have no effect on an ongoing transfer.

Decomposition:
- Shared package p2s_pkg holds:
  - state encoding localparams (IDLE=2'b00, SHIFT=2'b01, LATCH=2'b10);
  - a $clog2-based width helper.
- One natural sub-module: p2s_sclk_gen.
  - Divider producing phase strobes (rise_en, fall_en) and registered sclk.
  - Enabled only in SHIFT.
- Shift register, FSM and handshake stay in p2s_ser.

Test Plan:
- DATA_BITS=16, CLK_DIV=2, LSB_FIRST=0, data=16'hA5C3, one start pulse:
  - sout at the 16 sclk rises = 1010_0101_1100_0011;
  - busy high 66 cycles; sen high 2 cycles after the last rise; done pulse once.
- Same with LSB_FIRST=1, data=16'h0001 -> first sampled bit 1, remaining 15 bits 0.
- start held high 200 cycles -> exactly one transfer (16 rises, one done).
- Extra start edge at cycle 10 of a transfer -> ignored; one transfer only.
- start edge in the done cycle -> second transfer begins with no gap.
- Reset mid-transfer:
  - rst at cycle 20 -> next cycle sclk=0, sout=0, busy=0, sen=0, sclr=0, no done.
  - rst released -> sclr=1 and a new start works normally.
- CLK_DIV=1, DATA_BITS=8, data=8'hFF -> sclk toggles every cycle; 8 rises; busy 18 cycles.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_ser serial transmitter: state encoding and
// counter width helper.
package p2s_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_LATCH = 2'b10;

    // One spare bit above $clog2 so a counter can hold its own terminal value.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/p2s_sclk_gen.sv
// Serial clock divider: sclk low for CLK_DIV cycles, then high for CLK_DIV
// cycles, while enabled; held low with a cleared divider otherwise.
module p2s_sclk_gen
    import p2s_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int              DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             phase_end;

    assign phase_end = en && (div_cnt == DIV_LAST);
    assign rise_en   = phase_end && !sclk;
    assign fall_en   = phase_end && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            sclk    <= !sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/p2s_ser.sv
// Parallel-to-serial transmitter for 74HC595-style chains: shift, latch, done.
// state | meaning: IDLE wait for start edge | SHIFT clock bits out | LATCH pulse sen
module p2s_ser
    import p2s_pkg::*;
#(
    parameter int DATA_BITS    = 16,
    parameter int CLK_DIV      = 2,
    parameter int LSB_FIRST    = 0,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 sout,
    output logic                 sclr,
    output logic                 sen
);

    localparam int               BIT_W    = cnt_width(DATA_BITS);
    localparam int               LAT_W    = cnt_width(LATCH_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);

    logic [1:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [LAT_W-1:0]     lat_cnt;
    logic                 start_d;
    logic                 last_bit;
    logic                 trig;
    logic                 rise_en;
    logic                 fall_en;

    assign trig = start && !start_d && (state == ST_IDLE);

    p2s_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_SHIFT),
        .sclk    (sclk),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            lat_cnt  <= '0;
            last_bit <= 1'b0;
            start_d  <= 1'b0;
            sout     <= 1'b0;
            sen      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclr     <= 1'b0;
        end else begin
            sclr    <= 1'b1;
            start_d <= start;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        shreg    <= data;
                        bit_cnt  <= '0;
                        last_bit <= 1'b0;
                        sout     <= (LSB_FIRST != 0) ? data[0] : data[DATA_BITS-1];
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Decide "last bit" at the rise so the fall only acts on a flag.
                    if (rise_en) last_bit <= (bit_cnt == BIT_LAST);
                    if (fall_en) begin
                        if (last_bit) begin
                            sout    <= 1'b0;
                            sen     <= 1'b1;
                            lat_cnt <= LAT_LOAD;
                            state   <= ST_LATCH;
                        end else begin
                            if (LSB_FIRST != 0) begin
                                shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                                sout  <= shreg[1];
                            end else begin
                                shreg <= {shreg[DATA_BITS-2:0], 1'b0};
                                sout  <= shreg[DATA_BITS-2];
                            end
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (lat_cnt == '0) begin
                        sen   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_ser.sv
// Bench for p2s_ser: three configurations, transfer-level reference model.
module tb_p2s_ser;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] data0, data1;
    logic [7:0]  data2;
    logic [2:0]  busy_v, done_v, sclk_v, sout_v, sclr_v, sen_v;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    p2s_ser #(.DATA_BITS(16), .CLK_DIV(2), .LSB_FIRST(0), .LATCH_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .data(data0), .busy(busy_v[0]),
        .done(done_v[0]), .sclk(sclk_v[0]), .sout(sout_v[0]), .sclr(sclr_v[0]), .sen(sen_v[0]));

    p2s_ser #(.DATA_BITS(16), .CLK_DIV(2), .LSB_FIRST(1), .LATCH_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .data(data1), .busy(busy_v[1]),
        .done(done_v[1]), .sclk(sclk_v[1]), .sout(sout_v[1]), .sclr(sclr_v[1]), .sen(sen_v[1]));

    p2s_ser #(.DATA_BITS(8), .CLK_DIV(1), .LSB_FIRST(0), .LATCH_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .data(data2), .busy(busy_v[2]),
        .done(done_v[2]), .sclk(sclk_v[2]), .sout(sout_v[2]), .sclr(sclr_v[2]), .sen(sen_v[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int nbits_of(input int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic int cdiv_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    task automatic set_data(input int k, input logic [15:0] w);
        case (k)
            0:       data0 = w;
            1:       data1 = w;
            default: data2 = w[7:0];
        endcase
    endtask

    // mode 0: single pulse, 1: start held high, 2: extra edge at cycle 10.
    // Called and returns at a negedge; returns in the cycle done is seen.
    task automatic xfer(input int k, input logic [15:0] word, input int mode);
        int n = nbits_of(k);
        int cd = cdiv_of(k);
        int rises = 0, busy_len = -1, first_rise = -1, last_rise = -1;
        int sen_cnt = 0, sen_first = -1, sen_sclk = 0, done_cnt = 0, done_c = -1, bad_sclr = 0;
        logic [15:0] got = '0;
        logic [15:0] exp_bits = '0;
        logic        prev_sclk = 1'b0;
        for (int i = 0; i < n; i++)
            exp_bits[i] = (k == 1) ? word[i] : word[n-1-i];
        set_data(k, word);
        start_v[k] = 1'b1;
        for (int c = 1; c <= 600 && done_c < 0; c++) begin
            @(negedge clk);
            if (sclk_v[k] && !prev_sclk) begin
                if (rises < 16) got[rises] = sout_v[k];
                rises++;
                if (first_rise < 0) first_rise = c;
                last_rise = c;
            end
            prev_sclk = sclk_v[k];
            if (!busy_v[k] && busy_len < 0) busy_len = c - 1;
            if (sen_v[k]) begin
                sen_cnt++;
                if (sen_first < 0) sen_first = c;
                if (sclk_v[k]) sen_sclk++;
            end
            if (done_v[k]) begin
                done_cnt++;
                done_c = c;
            end
            if (!sclr_v[k]) bad_sclr++;
            if (c == 1) begin
                if (mode != 1) start_v[k] = 1'b0;
                set_data(k, 16'($urandom));
            end
            if (mode == 2 && c == 10) start_v[k] = 1'b1;
            if (mode == 2 && c == 11) start_v[k] = 1'b0;
        end
        chk("rise_count", rises, n);
        chk("bits_at_rise", int'(got), int'(exp_bits));
        chk("first_rise_latency", first_rise, cd + 1);
        chk("busy_cycles", busy_len, 2 * cd * n + 2);
        chk("sen_cycles", sen_cnt, 2);
        chk("sen_after_last_rise", sen_first - last_rise, cd);
        chk("sclk_during_sen", sen_sclk, 0);
        chk("done_pulses", done_cnt, 1);
        chk("done_when_busy_low", done_c, busy_len + 1);
        chk("sclr_low_in_xfer", bad_sclr, 0);
    endtask

    task automatic quiet(input int k, input int ncyc);
        int act = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busy_v[k] || sclk_v[k] || sen_v[k] || done_v[k]) act++;
        end
        chk("no_activity", act, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_v = '0;
        data0 = '0;
        data1 = '0;
        data2 = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("reset_outputs", int'({busy_v[k], done_v[k], sclk_v[k], sout_v[k], sen_v[k], sclr_v[k]}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("sclr_after_reset", int'(sclr_v), 7);

        xfer(0, 16'hA5C3, 0);
        quiet(0, 5);
        xfer(1, 16'h0001, 0);
        quiet(1, 5);
        xfer(2, 16'h00FF, 0);
        quiet(2, 5);

        xfer(0, 16'h3C96, 1);
        quiet(0, 200);
        start_v[0] = 1'b0;
        @(negedge clk);

        xfer(0, 16'h5A0F, 2);
        quiet(0, 80);

        // Second start lands in the done cycle of the first.
        xfer(1, 16'h8421, 0);
        xfer(1, 16'h7EE1, 0);
        quiet(1, 5);

        set_data(0, 16'hFFFF);
        start_v[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start_v[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", int'({sclk_v[0], sout_v[0], busy_v[0], sen_v[0], done_v[0]}), 0);
        chk("abort_sclr", int'(sclr_v[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("sclr_released", int'(sclr_v[0]), 1);
        quiet(0, 10);
        xfer(0, 16'hC0DE, 0);

        for (int r = 0; r < 8; r++) begin
            int k = int'($urandom_range(0, 2));
            quiet(k, int'($urandom_range(0, 5)));
            xfer(k, 16'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
